// File: rtl/mu0_mem_resp.sv
// mu0_mem_resp: memory-side responder for the MU0 Rd/Wr bus.
// Holds 2^AW_MEM x 16-bit words. A request sampled in IDLE is latched, held
// for WAIT cycles, then acknowledged with a one-cycle Ready pulse (ACK).
// Addresses with bits set above AW_MEM-1 read as zero and discard writes.
//
// Ports:
//   Clk    in   1   rising-edge clock
//   Reset  in   1   asynchronous active-low reset
//   Addr   in  12   word address
//   Din    in  16   write data
//   Rd     in   1   read request (level)
//   Wr     in   1   write request (level, wins over Rd)
//   Dout   out 16   registered read data, held until next completed read
//   Ready  out  1   registered one-cycle acknowledge
module mu0_mem_resp #(
  parameter int unsigned WAIT   = 2,
  parameter int unsigned AW_MEM = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Addr,
  input  logic [15:0] Din,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] Dout,
  output logic        Ready
);

  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);
  localparam int unsigned DEPTH    = 1 << AW_MEM;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic [15:0] dout_q;
  logic        ready_q;

  logic [15:0] mem [DEPTH];

  logic              in_idle;
  logic [11:0]       eff_addr;
  logic [15:0]       eff_din;
  logic              eff_wr;
  logic              enter_ack;
  logic              in_range;
  logic [AW_MEM-1:0] idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Rd || Wr) begin
          addr_d = Addr;
          din_d  = Din;
          wr_d   = Wr;
          if (WAIT_CNT == 4'd0) begin
            state_d = S_ACK;
          end else begin
            cnt_d   = WAIT_CNT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With WAIT=0 the ACK is entered straight from IDLE, before the latches
  // hold the request, so the access uses the live bus in that case.
  always_comb begin
    in_idle   = (state_q == S_IDLE);
    eff_addr  = in_idle ? Addr : addr_q;
    eff_din   = in_idle ? Din  : din_q;
    eff_wr    = in_idle ? Wr   : wr_q;
    enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
    in_range  = ((eff_addr >> AW_MEM) == '0);
    idx       = eff_addr[AW_MEM-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      ready_q <= (state_d == S_ACK);
      if (enter_ack && !eff_wr) dout_q <= in_range ? mem[idx] : '0;
    end
  end

  // Storage is never reset; Reset gates the write so an aborted write
  // cannot land on the edge where reset is held.
  always_ff @(posedge Clk) begin
    if (Reset && enter_ack && eff_wr && in_range) mem[idx] <= eff_din;
  end

  assign Dout  = dout_q;
  assign Ready = ready_q;

endmodule

// File: tb/tb_mu0_mem_resp.sv
// Randomized scoreboard bench for mu0_mem_resp (WAIT=2, AW_MEM=8).
module tb_mu0_mem_resp;
  localparam int unsigned WAIT = 2;
  localparam int unsigned AW   = 8;
  localparam int          PER  = 10;
  localparam logic [11:0] LIMIT = 12'(1 << AW);

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [11:0] Addr  = '0;
  logic [15:0] Din   = '0;
  logic        Rd    = 1'b0;
  logic        Wr    = 1'b0;
  logic [15:0] Dout;
  logic        Ready;

  mu0_mem_resp #(.WAIT(WAIT), .AW_MEM(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .Din(Din),
    .Rd(Rd), .Wr(Wr), .Dout(Dout), .Ready(Ready)
  );

  always #(PER/2) Clk = ~Clk;

  typedef struct {
    logic [15:0] data;
    time         t_samp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] mem_m [int];
  int          written[$];
  logic [15:0] dout_m = '0;

  // Reference: Wr wins; out-of-range writes vanish, out-of-range reads give 0;
  // Dout only changes on a read.
  function automatic logic [15:0] model_op(input logic rd, input logic wr,
                                           input logic [11:0] a, input logic [15:0] d);
    if (wr) begin
      if (a < LIMIT) begin
        if (!mem_m.exists(int'(a))) written.push_back(int'(a));
        mem_m[int'(a)] = d;
      end
    end else if (rd) begin
      dout_m = (a < LIMIT) ? mem_m[int'(a)] : 16'h0000;
    end
    return dout_m;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One request pulse, random junk on the bus while busy, then idle.
  task automatic txn(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
    bit seen = 1'b0;
    @(negedge Clk);
    Rd = rd; Wr = wr; Addr = a; Din = d;
    @(posedge Clk);
    sb.push_back('{model_op(rd, wr, a, d), $time});
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge Clk);
      seen = Ready;
      Rd   = 1'($urandom_range(0, 1));
      Wr   = 1'($urandom_range(0, 1));
      Addr = 12'($urandom);
      Din  = 16'($urandom);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got no Ready expected Ready within 30 cycles at %0t", $time);
    end
    @(posedge Clk);
    @(negedge Clk);
    Rd = 1'b0; Wr = 1'b0;
  endtask

  // Monitor: Ready must arrive in the (WAIT+1)th cycle after the sampling
  // edge (negedge sample => WAIT*PER + PER/2), be one cycle wide, carry the
  // expected Dout; outside Ready, Dout must hold the last read value.
  initial begin
    bit          prev = 1'b0;
    logic [15:0] hold = '0;
    exp_t        e;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        hold = '0;
        prev = 1'b0;
      end else if (Ready) begin
        check1("ready_width", prev, 1'b0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_ready: got Ready=1 expected Ready=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check16("dout_at_ack", Dout, e.data);
          n_cmp++;
          if (($time - e.t_samp) != time'(WAIT * PER + PER / 2)) begin
            n_fail++;
            $display("FAIL ready_latency: got %0t expected %0t after sampling edge",
                     $time - e.t_samp, time'(WAIT * PER + PER / 2));
          end
          hold = e.data;
        end
        prev = 1'b1;
      end else begin
        check16("dout_hold", Dout, hold);
        prev = 1'b0;
      end
    end
  end

  initial begin
    logic [11:0] a;
    // Reset state
    #3 Reset = 1'b0;
    #14;
    check16("reset_dout", Dout, 16'h0000);
    check1("reset_ready", Ready, 1'b0);
    #10 Reset = 1'b1;

    // Directed cases
    txn(1'b0, 1'b1, 12'h000, 16'h5A5A);
    txn(1'b0, 1'b1, 12'h010, 16'hFFFE);   // Dout stays 0
    txn(1'b1, 1'b0, 12'h010, 16'h0000);   // FFFE
    txn(1'b1, 1'b1, 12'h020, 16'hFFFA);   // both high -> write
    txn(1'b1, 1'b0, 12'h020, 16'h0000);   // FFFA
    txn(1'b0, 1'b1, 12'h100, 16'h1234);   // out of range, discarded
    txn(1'b1, 1'b0, 12'h100, 16'h0000);   // 0
    txn(1'b1, 1'b0, 12'h000, 16'h0000);   // 5A5A unaffected

    // Reset mid-WAIT aborts a write
    @(negedge Clk);
    Wr = 1'b1; Rd = 1'b0; Addr = 12'h010; Din = 16'hAAAA;
    @(posedge Clk);
    #12;
    Wr = 1'b0;
    Reset = 1'b0;
    #1;
    check16("async_reset_dout", Dout, 16'h0000);
    check1("async_reset_ready", Ready, 1'b0);
    dout_m = '0;
    #9 Reset = 1'b1;
    repeat (4) @(negedge Clk);
    txn(1'b1, 1'b0, 12'h010, 16'h0000);   // still FFFE

    // Rd held high: a new sample every WAIT+2 cycles
    @(negedge Clk);
    Rd = 1'b1; Wr = 1'b0; Addr = 12'h010;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk);
      sb.push_back('{model_op(1'b1, 1'b0, 12'h010, 16'h0000), $time});
      if (k < 3) repeat (WAIT + 1) @(posedge Clk);
    end
    @(negedge Clk);
    Rd = 1'b0;
    repeat (4) @(negedge Clk);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(256, 4095))
                                        : 12'($urandom_range(0, 255));
        txn(1'($urandom_range(0, 1)), 1'b1, a, 16'($urandom));
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(256, 4095))
                                        : 12'(written[$urandom_range(0, written.size() - 1)]);
        txn(1'b1, 1'b0, a, 16'($urandom));
      end
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end
    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
